// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable Moore serial-pattern detector.
// Keeps a shift history of accepted bits and a fill count of how many of
// them belong to the current search. It raises seq_out for one accepted bit
// when the last len_r bits equal the low len_r bits of the pattern, and it
// keeps a saturating count of matches.
module seq_detector_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(8'b0000_0011),
  parameter int                 RESET_LEN     = 4,
  parameter bit                 RESET_OVERLAP = 1'b1,
  localparam int                LEN_W         = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               seq_out,
  output logic [CNT_W-1:0]   match_count
);

  // Registered configuration
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  // Detection state
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seq_out;
  logic [CNT_W-1:0]   r_count;

  // Combinational helpers
  logic [LEN_W-1:0]   w_len_clamped;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W:0]     w_fill_inc;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic               w_count_full;

  // Clamp the requested length into the supported range 1..MAX_LEN
  always_comb begin
    w_len_clamped = cfg_len;
    if (cfg_len == '0) begin
      w_len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      w_len_clamped = LEN_W'(MAX_LEN);
    end
  end

  // Mask selecting the bits of the history that take part in the compare
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign w_mask[gi] = (LEN_W'(gi) < r_len);
    end
  endgenerate

  // Next history and fill if the current bit is accepted, and the match decision.
  // The increment is one bit wider so that fill+1 cannot wrap before the clamp.
  always_comb begin
    w_hist_next  = {r_hist[MAX_LEN-2:0], seq_in};
    w_fill_inc   = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    w_fill_next  = (w_fill_inc >= {1'b0, r_len}) ? r_len : w_fill_inc[LEN_W-1:0];
    w_match      = (w_fill_next == r_len) &&
                   (((w_hist_next ^ r_pattern) & w_mask) == '0);
    w_count_full = (r_count == {CNT_W{1'b1}});
  end

  // Configuration register: loaded from the cfg_* inputs on cfg_load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pattern <= RESET_PATTERN;
      r_len     <= LEN_W'(RESET_LEN);
      r_overlap <= RESET_OVERLAP;
    end else if (cfg_load) begin
      r_pattern <= cfg_pattern;
      r_len     <= w_len_clamped;
      r_overlap <= cfg_overlap;
    end
  end

  // Detection state: cfg_load restarts the search, an accepted bit advances it,
  // otherwise everything (including seq_out) holds
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_seq_out <= 1'b0;
      r_count   <= '0;
    end else if (cfg_load) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_seq_out <= 1'b0;
      r_count   <= '0;
    end else if (in_valid) begin
      r_hist    <= w_hist_next;
      r_seq_out <= w_match;
      // Without overlap a match consumes its bits; the next one needs len_r fresh bits
      r_fill    <= (w_match && !r_overlap) ? '0 : w_fill_next;
      if (w_match && !w_count_full) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign seq_out     = r_seq_out;
  assign match_count = r_count;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore serial-pattern detector and the successor of the fixed 4-bit "0011" detector. Pattern, pattern length (1..MAX_LEN) and overlap mode are runtime-configurable. Input bits are qualified by a valid strobe. Sits after the serial input synchroniser and drives the match indicator plus a saturating match counter readable by the status logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter
RESET_PATTERN, 8'b0000_0011, pattern loaded at reset (right-aligned, MAX_LEN bits)
RESET_LEN, 4, pattern length loaded at reset
RESET_OVERLAP, 1, overlap mode loaded at reset
LEN_W (local), $clog2(MAX_LEN+1), width of length fields

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
seq_in  in  1  serial data bit
in_valid  in  1  seq_in accepted on this clock edge when high
cfg_load  in  1  latch cfg_* and restart detection
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = restart after a match
seq_out  out  1  Moore match output
match_count  out  CNT_W  number of matches since reset/cfg_load, saturating

Behaviour:
- Reset (asynchronous):
  - pattern_r=RESET_PATTERN, len_r=RESET_LEN, overlap_r=RESET_OVERLAP.
  - hist=0, fill=0, seq_out=0, match_count=0.
- State:
  - hist: MAX_LEN-bit shift history.
  - fill: count of valid history bits, 0..len_r.
  - Registered config: pattern_r, len_r, overlap_r.
- Length clamp at load: cfg_len=0 -> 1; cfg_len>MAX_LEN -> MAX_LEN.
- cfg_load=1 (highest priority, synchronous):
  - Latch config; clear hist, fill, seq_out, match_count.
  - A bit presented with in_valid in the same cycle is discarded.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[MAX_LEN-2:0], seq_in}.
  - fill_n = min(fill+1, len_r).
  - match = (fill_n == len_r) && (hist_n[len_r-1:0] == pattern_r[len_r-1:0]). Bits above len_r are ignored.
  - seq_out <= match, registered; visible the cycle after the accepting edge.
  - On match: match_count <= match_count+1, saturating at all-ones (no wrap).
  - On match with overlap_r=0: fill <= 0, so the next match needs len_r fresh bits. With overlap_r=1, fill stays at len_r.
- in_valid=0: all state holds; seq_out keeps its value (Moore: changes only on an accepted bit). With in_valid tied high, seq_out is a 1-cycle pulse per match.
- Latency: matching bit accepted at edge N -> seq_out=1 after edge N, until the next accepted bit or cfg_load.
- Reset mid-stream: partial history lost; detection restarts from an empty history with the RESET_* configuration.
- len_r=1: every accepted bit equal to pattern_r[0] matches; both overlap modes behave identically.

Test Plan:
1. After reset, in_valid=1 continuously, stream 1,0,0,1,1,0 -> seq_out=1 only in the cycle after the 5th bit; match_count=1.
2. cfg_load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 -> seq_out pulses after bits 3 and 5; count=2. Repeat with overlap=0 -> pulse after bit 3 only; count=1.
3. Reset config; stream 0,0,1,1 with in_valid low for 3 cycles between bits -> seq_out rises only after the 4th accepted bit and stays 1 until the next accepted bit.
4. CNT_W=8, pattern len=1, pattern[0]=1, 300 accepted 1s -> match_count saturates at 255; seq_out stays 1.
5. cfg_load with cfg_len=0 and in_valid=1 in the same cycle -> bit discarded; len_r=1; count=0. cfg_len=15 (MAX_LEN=8) -> len_r=8.
6. Assert reset after bits 0,0,1; then send 1 -> no match. Send 0,0,1,1 -> match; count=1.
